us_timer: RTL and testbench
===========================

// Module: us_timer
// PURPOSE
//  Microsecond timebase consumer: the receive side of the 1 us strobe (pluse_us) produced in clk_sys.
//  Keeps a free-running us timestamp and a programmable one-shot/periodic us timer (start/stop/done).
//  Checks strobe cadence against clk_sys and flags a missing or early strobe.
//  Serves as the shared delay/timeout engine for downstream control logic in the clk_sys domain.
// PARAMETERS
//  CNT_W       24   width of timer period / remaining count (us)
//  TS_W        32   width of free-running timestamp (us)
//  CLK_PER_US  100  nominal clk_sys cycles between pluse_us strobes
//  GAP_TOL     4    allowed deviation (cycles) of strobe spacing before tick_err
// PORTS
//  clk_sys    in   1      system clock; the only clock
//  rst_n      in   1      asynchronous active-low reset
//  pluse_us   in   1      1-cycle strobe, nominally every CLK_PER_US cycles
//  cfg_period in   CNT_W  timer period in us, sampled on accepted start
//  cfg_mode   in   1      0 = one-shot, 1 = periodic, sampled on accepted start
//  start      in   1      1-cycle request: load and run (restart if already running)
//  stop       in   1      1-cycle request: abort, return to IDLE
//  err_clr    in   1      clears sticky tick_err
//  busy       out  1      timer running
//  done       out  1      1-cycle pulse at period expiry
//  remain     out  CNT_W  remaining us of current period
//  timestamp  out  TS_W   free-running us count
//  tick_err   out  1      sticky strobe-cadence error
// BEHAVIOUR
//  Reset: busy=0, done=0, remain=0, timestamp=0, tick_err=0, state=IDLE, gap counter=0, first-strobe flag set.
//  timestamp: +1 on every pluse_us regardless of timer state; wraps 2^TS_W-1 -> 0 with no flag.
//  States: IDLE, RUN. done is a registered 1-cycle pulse, not a separate state.
//  Priority each cycle: stop > start > pluse_us decrement.
//  IDLE + start, cfg_period!=0: latch period/mode; next cycle busy=1, remain=cfg_period, state=RUN.
//  start with cfg_period==0: ignored in either state (IDLE stays IDLE; RUN continues unchanged).
//  RUN + pluse_us, remain>1: remain-1.
//  RUN + pluse_us, remain==1: done=1 next cycle;
//    one-shot -> IDLE, busy=0, remain=0;
//    periodic -> remain=latched period, stay RUN, busy stays 1.
//  RUN + start (period!=0): reload remain/period/mode next cycle; coincident pluse_us is discarded; no done.
//  stop (any state): next cycle IDLE, busy=0, remain=0, no done; overrides coincident start/expiry.
//  Quantisation: the first decrement is the first pluse_us after start is accepted (a strobe in the
//    start cycle is not counted); elapsed time from start to done is within (P-1, P] us.
//  Latency: start -> busy after 1 cycle; expiring pluse_us -> done after 1 cycle.
//  Cadence monitor: gap counter counts clk_sys cycles since the last pluse_us and saturates at
//    CLK_PER_US+GAP_TOL+1.
//    - Late: gap > CLK_PER_US+GAP_TOL -> tick_err=1; the gap counter keeps saturating until the next strobe.
//    - Early: pluse_us with gap < CLK_PER_US-GAP_TOL -> tick_err=1, unless this is the first strobe
//      since reset (first-strobe flag).
//    - Each pluse_us restarts the gap counter at 1.
//    - tick_err is sticky. err_clr clears it; a simultaneous new error wins (tick_err stays 1).
//  Timer operation is unaffected by tick_err.
//  Reset mid-operation: all state returns to reset values asynchronously; no done is emitted.
// STRUCTURE
//  us_timer_pkg: state enum (IDLE, RUN), mode constants (MODE_ONESHOT=0, MODE_PERIODIC=1).
//  Sub-module pluse_gap_mon: gap counter, first-strobe flag, early/late compare, sticky tick_err.
//  Top holds the timestamp counter and the timer FSM.
// TESTING
//  1 One-shot: CLK_PER_US=100, period=3, start -> done exactly once, 1 cycle after 3rd strobe; then busy=0, remain=0.
//  2 Periodic: period=2, run 5 periods -> done every 200 cycles; busy held 1; stop -> busy=0, no further done.
//  3 Restart: period=10, start again after 4 strobes with period=5 and a strobe in the same cycle
//    -> remain=5, no done; done after 5 more strobes.
//  4 Stop vs expiry: stop in the same cycle as the expiring strobe -> no done; IDLE.
//  5 Cadence: strobe spacing 100 -> tick_err=0; spacing 106 -> tick_err=1 at cycle 105; err_clr -> 0;
//    spacing 94 -> tick_err=1.
//  6 Wrap/reset: preload timestamp near 2^TS_W-1 (forced) -> 0 after wrap; assert rst_n=0 mid-RUN
//    -> all outputs 0 immediately.

Source files
------------

// File: rtl/us_timer_pkg.sv
// Shared types and constants for the microsecond timer and its strobe-cadence monitor.
package us_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam int CNT_W_DEF      = 24;
  localparam int TS_W_DEF       = 32;
  localparam int CLK_PER_US_DEF = 100;
  localparam int GAP_TOL_DEF    = 4;

endpackage

// File: rtl/us_timer_if.sv
// Timer control/status bundle: the client side drives strobe and requests, the timer answers with status.
// Handshake: start/stop/err_clr/pluse_us are single-cycle requests, acted on at the clock edge that samples them; no ready.
interface us_timer_if
  import us_timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TS_W  = TS_W_DEF
);
    logic             pluse_us;
    logic [CNT_W-1:0] cfg_period;
    logic             cfg_mode;
    logic             start;
    logic             stop;
    logic             err_clr;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remain;
    logic [TS_W-1:0]  timestamp;
    logic             tick_err;
    state_e           state_dbg;

    modport master (
        output pluse_us, cfg_period, cfg_mode, start, stop, err_clr,
        input  busy, done, remain, timestamp, tick_err, state_dbg
    );

    modport slave (
        input  pluse_us, cfg_period, cfg_mode, start, stop, err_clr,
        output busy, done, remain, timestamp, tick_err, state_dbg
    );
endinterface

// File: rtl/us_timer_pluse_gap_mon.sv
// Strobe cadence monitor: counts clk_sys cycles between pluse_us strobes and raises a sticky
// tick_err when a strobe arrives too early or fails to arrive in time.
module pluse_gap_mon #(
    parameter int CLK_PER_US = 100,
    parameter int GAP_TOL    = 4
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic pluse_us,
    input  logic err_clr,
    output logic tick_err
);
    localparam int GAP_W = $clog2(CLK_PER_US + GAP_TOL + 2);
    localparam logic [GAP_W-1:0] GAP_SAT   = GAP_W'(CLK_PER_US + GAP_TOL + 1);
    localparam logic [GAP_W-1:0] GAP_LATE  = GAP_W'(CLK_PER_US + GAP_TOL);
    localparam logic [GAP_W-1:0] GAP_EARLY = GAP_W'(CLK_PER_US - GAP_TOL);

    logic [GAP_W-1:0] gap_q, gap_d;
    logic             first_q, first_d;
    logic             err_q, err_d;
    logic             late, early;

    always_comb begin
        gap_d   = gap_q;
        first_d = first_q;
        // gap_q at a strobe equals the spacing from the previous strobe
        late    = (gap_q > GAP_LATE);
        early   = pluse_us && !first_q && (gap_q < GAP_EARLY);
        if (pluse_us) begin
            gap_d   = GAP_W'(1);
            first_d = 1'b0;
        end else if (gap_q < GAP_SAT) begin
            gap_d = gap_q + GAP_W'(1);
        end
        err_d = err_q;
        if (late || early) err_d = 1'b1;
        else if (err_clr)  err_d = 1'b0;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            gap_q   <= '0;
            first_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            gap_q   <= gap_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

    assign tick_err = err_q;
endmodule

// File: rtl/us_timer.sv
// Microsecond timebase consumer: free-running us timestamp plus a one-shot/periodic us timer,
// with strobe cadence checking delegated to pluse_gap_mon.
module us_timer
  import us_timer_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int TS_W       = TS_W_DEF,
    parameter int CLK_PER_US = CLK_PER_US_DEF,
    parameter int GAP_TOL    = GAP_TOL_DEF
) (
    input logic        clk_sys,
    input logic        rst_n,
    us_timer_if.slave  bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic [TS_W-1:0]  ts_q, ts_d;

    always_comb begin
        ts_d = ts_q;
        if (bus.pluse_us) ts_d = ts_q + TS_W'(1);
    end

    // Priority: stop, then a valid start (which swallows a coincident strobe), then decrement
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        period_d = period_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        if (bus.stop) begin
            state_d  = ST_IDLE;
            remain_d = '0;
        end else if (bus.start && (bus.cfg_period != '0)) begin
            state_d  = ST_RUN;
            remain_d = bus.cfg_period;
            period_d = bus.cfg_period;
            mode_d   = bus.cfg_mode;
        end else if ((state_q == ST_RUN) && bus.pluse_us) begin
            if (remain_q == CNT_W'(1)) begin
                done_d = 1'b1;
                if (mode_q == MODE_PERIODIC) begin
                    remain_d = period_q;
                end else begin
                    state_d  = ST_IDLE;
                    remain_d = '0;
                end
            end else begin
                remain_d = remain_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
            period_q <= '0;
            mode_q   <= MODE_ONESHOT;
            done_q   <= 1'b0;
            ts_q     <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
            ts_q     <= ts_d;
        end
    end

    pluse_gap_mon #(
        .CLK_PER_US (CLK_PER_US),
        .GAP_TOL    (GAP_TOL)
    ) u_gap_mon (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .pluse_us (bus.pluse_us),
        .err_clr  (bus.err_clr),
        .tick_err (bus.tick_err)
    );

    assign bus.busy      = (state_q == ST_RUN);
    assign bus.done      = done_q;
    assign bus.remain    = remain_q;
    assign bus.timestamp = ts_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_us_timer.sv
// Directed bench for us_timer: done pulses are checked against an expected-cycle queue,
// status outputs are checked at fixed points of the stimulus sequence.
module tb_us_timer;
  import us_timer_pkg::*;

  // clock / reset
  logic clk_sys = 1'b0;
  logic rst_n;
  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  us_timer_if #(.CNT_W(24), .TS_W(32)) bus ();

  us_timer #(
    .CNT_W      (24),
    .TS_W       (32),
    .CLK_PER_US (100),
    .GAP_TOL    (4)
  ) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int          since = 0;
  logic [31:0] ts_exp = '0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: apply inputs for exactly one cycle, starting and ending at a falling edge
  task automatic step(input logic pl, input logic st, input logic sp, input logic clr,
                      input logic [23:0] per, input logic md);
    bus.pluse_us   = pl;
    bus.start      = st;
    bus.stop       = sp;
    bus.err_clr    = clr;
    bus.cfg_period = per;
    bus.cfg_mode   = md;
    @(negedge clk_sys);
    bus.pluse_us   = 1'b0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.err_clr    = 1'b0;
    bus.cfg_period = '0;
    bus.cfg_mode   = 1'b0;
    if (pl) begin
      since  = 0;
      ts_exp = ts_exp + 32'd1;
    end else begin
      since++;
    end
  endtask

  task automatic idle_to(input int target);
    while (since < target) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // strobe placed `spacing` cycles after the previous one; an expiring strobe queues its done cycle
  task automatic strobe(input int spacing, input logic expire, input logic st,
                        input logic [23:0] per, input logic md, input logic sp);
    idle_to(spacing - 1);
    if (expire) exp_q.push_back(cyc + 1);
    step(1'b1, st, sp, 1'b0, per, md);
  endtask

  task automatic tick100(input logic expire);
    strobe(100, expire, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // scoreboard: every done pulse must match the head of the expected queue
  always @(negedge clk_sys) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL done_unexpected observed=cycle %0d expected=no done", cyc);
      end
      if (exp_q.size() > 0) chk("done_cycle", cyc, exp_q.pop_front());
    end
  end

  initial begin
    rst_n          = 1'b0;
    bus.pluse_us   = 1'b0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.err_clr    = 1'b0;
    bus.cfg_period = '0;
    bus.cfg_mode   = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_remain", 32'(bus.remain), 0);
    chk("rst_timestamp", bus.timestamp, 0);
    chk("rst_tick_err", 32'(bus.tick_err), 0);
    chk("rst_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk_sys);

    // first strobe after reset is exempt from the early check
    strobe(1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("first_strobe_err", 32'(bus.tick_err), 0);

    // one-shot, period 3
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'd3, MODE_ONESHOT);
    chk("os_busy", 32'(bus.busy), 1);
    chk("os_remain", 32'(bus.remain), 3);
    chk("os_state", 32'(bus.state_dbg), 32'(ST_RUN));
    tick100(1'b0);
    tick100(1'b0);
    chk("os_remain_last", 32'(bus.remain), 1);
    tick100(1'b1);
    chk("os_end_busy", 32'(bus.busy), 0);
    chk("os_end_remain", 32'(bus.remain), 0);
    chk("os_end_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    chk("os_timestamp", bus.timestamp, ts_exp);

    // periodic, period 2, five periods then stop
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'd2, MODE_PERIODIC);
    for (int i = 0; i < 10; i++) begin
      tick100(i % 2 == 1);
      chk("per_busy", 32'(bus.busy), 1);
    end
    chk("per_remain_reload", 32'(bus.remain), 2);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("per_stop_busy", 32'(bus.busy), 0);
    chk("per_stop_remain", 32'(bus.remain), 0);
    tick100(1'b0);
    tick100(1'b0);

    // zero period start is ignored
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'd0, MODE_ONESHOT);
    chk("zero_start_busy", 32'(bus.busy), 0);

    // restart with coincident strobe
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'd10, MODE_ONESHOT);
    for (int i = 0; i < 4; i++) tick100(1'b0);
    chk("rs_remain_before", 32'(bus.remain), 6);
    strobe(100, 1'b0, 1'b1, 24'd5, MODE_ONESHOT, 1'b0);
    chk("rs_remain_reload", 32'(bus.remain), 5);
    chk("rs_busy", 32'(bus.busy), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'd0, MODE_ONESHOT);
    chk("rs_zero_start_keeps", 32'(bus.remain), 5);
    for (int i = 0; i < 4; i++) tick100(1'b0);
    chk("rs_remain_last", 32'(bus.remain), 1);
    tick100(1'b1);
    chk("rs_end_busy", 32'(bus.busy), 0);

    // stop coincident with the expiring strobe
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'd2, MODE_ONESHOT);
    tick100(1'b0);
    chk("sx_remain", 32'(bus.remain), 1);
    strobe(100, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("sx_busy", 32'(bus.busy), 0);
    chk("sx_remain_end", 32'(bus.remain), 0);
    chk("sx_state", 32'(bus.state_dbg), 32'(ST_IDLE));

    // cadence monitor
    chk("cad_100_err", 32'(bus.tick_err), 0);
    idle_to(104);
    chk("cad_late_pre", 32'(bus.tick_err), 0);
    idle_to(105);
    chk("cad_late_err", 32'(bus.tick_err), 1);
    strobe(106, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("cad_sticky", 32'(bus.tick_err), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    chk("cad_clr", 32'(bus.tick_err), 0);
    strobe(96, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("cad_96_ok", 32'(bus.tick_err), 0);
    strobe(104, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("cad_104_ok", 32'(bus.tick_err), 0);
    strobe(94, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("cad_early_err", 32'(bus.tick_err), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    chk("cad_clr2", 32'(bus.tick_err), 0);

    // timestamp wrap
    force dut.ts_q = 32'hFFFF_FFFE;
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    release dut.ts_q;
    ts_exp = 32'hFFFF_FFFE;
    chk("ts_preload", bus.timestamp, ts_exp);
    tick100(1'b0);
    chk("ts_max", bus.timestamp, ts_exp);
    tick100(1'b0);
    chk("ts_wrap", bus.timestamp, 32'h0);

    // asynchronous reset in the middle of a periodic run
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'd5, MODE_PERIODIC);
    tick100(1'b0);
    chk("mr_remain", 32'(bus.remain), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_busy", 32'(bus.busy), 0);
    chk("mr_done", 32'(bus.done), 0);
    chk("mr_remain0", 32'(bus.remain), 0);
    chk("mr_timestamp", bus.timestamp, 0);
    chk("mr_tick_err", 32'(bus.tick_err), 0);
    chk("mr_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    repeat (2) @(negedge clk_sys);
    chk("exp_q_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
